seq_slice_comparator: RTL and testbench

- Parametrised, multi-cycle magnitude comparator for two DATA_W-bit operands.
- Compares SLICE_W bits per clock, MSB slice first, carrying an equal/greater cascade state between slices.
- Supports optional early termination, signed/unsigned mode, and cascade inputs for chaining wider compares.
- Used by datapath controllers that need a registered compare result with a start/done handshake.

---
 rtl/seq_slice_comparator.sv | 156 +++++++++++++++
 tb/tb_seq_slice_comparator.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seq_slice_comparator.sv
// seq_slice_comparator
//   Multi-cycle magnitude comparator. Compares two DATA_W-bit operands
//   SLICE_W bits per clock, most significant slice first, carrying an
//   equal/greater cascade state between slices. Signed compares are done
//   by flipping the operand sign bits (offset binary) and comparing unsigned.
//
// Ports
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   start        in   job request, sampled only in IDLE
//   a, b         in   operands, captured on an accepted start
//   signed_mode  in   1 = two's-complement compare, captured on start
//   cas_eq_in    in   cascade equal-in from a more-significant stage
//   cas_gt_in    in   cascade greater-in, used only when cas_eq_in = 0
//   busy         out  high while slices are being compared
//   done         out  one-cycle pulse when eq/gt/lt update
//   eq, gt, lt   out  registered compare result, held between jobs
module seq_slice_comparator #(
  parameter int DATA_W     = 8,
  parameter int SLICE_W    = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              signed_mode,
  input  logic              cas_eq_in,
  input  logic              cas_gt_in,
  output logic              busy,
  output logic              done,
  output logic              eq,
  output logic              gt,
  output logic              lt
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [IDX_W-1:0]    r_idx;
  logic                r_eq_c;
  logic                r_gt_c;
  logic                r_eq;
  logic                r_gt;
  logic                r_lt;

  logic [DATA_W-1:0]   w_a_conv;
  logic [DATA_W-1:0]   w_b_conv;
  logic [SLICE_W-1:0]  w_slice_a;
  logic [SLICE_W-1:0]  w_slice_b;
  logic                w_eq_n;
  logic                w_gt_n;
  logic                w_last;

  // Offset-binary conversion: only the sign bit is flipped in signed mode.
  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_conv
    if (gi == DATA_W - 1) begin : g_msb
      assign w_a_conv[gi] = a[gi] ^ signed_mode;
      assign w_b_conv[gi] = b[gi] ^ signed_mode;
    end else begin : g_lsb
      assign w_a_conv[gi] = a[gi];
      assign w_b_conv[gi] = b[gi];
    end
  end

  // Operands are shifted left after every slice, so the slice under test
  // always sits in the top SLICE_W bits.
  assign w_slice_a = r_a[DATA_W-1 -: SLICE_W];
  assign w_slice_b = r_b[DATA_W-1 -: SLICE_W];

  // Cascade update: once unequal, the decision is frozen.
  always_comb begin
    w_eq_n = r_eq_c;
    w_gt_n = r_gt_c;
    if (r_eq_c) begin
      if (w_slice_a > w_slice_b) begin
        w_eq_n = 1'b0;
        w_gt_n = 1'b1;
      end else if (w_slice_a < w_slice_b) begin
        w_eq_n = 1'b0;
        w_gt_n = 1'b0;
      end
    end
  end

  assign w_last = (r_idx == '0) || ((EARLY_EXIT != 0) && !w_eq_n);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_eq_c  <= 1'b0;
      r_gt_c  <= 1'b0;
      r_eq    <= 1'b0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a    <= w_a_conv;
            r_b    <= w_b_conv;
            r_eq_c <= cas_eq_in;
            r_gt_c <= cas_gt_in & ~cas_eq_in;
            r_idx  <= IDX_W'(NSLICE - 1);
          end
        end
        S_RUN: begin
          r_a    <= r_a << SLICE_W;
          r_b    <= r_b << SLICE_W;
          r_eq_c <= w_eq_n;
          r_gt_c <= w_gt_n;
          if (w_last) begin
            r_eq <= w_eq_n;
            r_gt <= w_gt_n;
            r_lt <= ~w_eq_n & ~w_gt_n;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign eq   = r_eq;
  assign gt   = r_gt;
  assign lt   = r_lt;

endmodule

// File: tb/tb_seq_slice_comparator.sv
// Directed bench for seq_slice_comparator. Two instances share the stimulus:
// one with early exit enabled, one that always walks every slice.
module tb_seq_slice_comparator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       signed_mode = 1'b0;
  logic       cas_eq_in = 1'b1;
  logic       cas_gt_in = 1'b0;

  logic busy1, done1, eq1, gt1, lt1;
  logic busy0, done0, eq0, gt0, lt0;

  int n_vec = 0;
  int n_err = 0;
  logic [2:0] prev1 = 3'b000;
  logic [2:0] prev0 = 3'b000;

  always #5 clk = ~clk;

  seq_slice_comparator #(.DATA_W(8), .SLICE_W(2), .EARLY_EXIT(1)) u_dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .cas_eq_in(cas_eq_in), .cas_gt_in(cas_gt_in),
    .busy(busy1), .done(done1), .eq(eq1), .gt(gt1), .lt(lt1)
  );

  seq_slice_comparator #(.DATA_W(8), .SLICE_W(2), .EARLY_EXIT(0)) u_dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .signed_mode(signed_mode), .cas_eq_in(cas_eq_in), .cas_gt_in(cas_gt_in),
    .busy(busy0), .done(done0), .eq(eq0), .gt(gt0), .lt(lt0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One job: expected latencies for both instances and expected {eq,gt,lt}.
  task automatic run_job(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                         input logic sm, input logic ce, input logic cg,
                         input int k1_exp, input int k0_exp, input logic [2:0] res_exp);
    int  k1, k0;
    bit  got1, got0;
    @(negedge clk);
    a = ta; b = tb_v; signed_mode = sm; cas_eq_in = ce; cas_gt_in = cg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "/busy_ee"}, busy1, 1);
    chk({tag, "/busy_full"}, busy0, 1);
    k1 = 0; k0 = 0; got1 = 0; got0 = 0;
    for (int c = 1; c <= 12 && !(got1 && got0); c++) begin
      @(posedge clk); #1;
      if (!got1) begin
        if (done1) begin
          got1 = 1; k1 = c;
          chk({tag, "/res_ee"}, {eq1, gt1, lt1}, res_exp);
          chk({tag, "/busy_ee_at_done"}, busy1, 0);
          prev1 = res_exp;
        end else begin
          chk({tag, "/hold_ee"}, {eq1, gt1, lt1}, prev1);
        end
      end
      if (!got0) begin
        if (done0) begin
          got0 = 1; k0 = c;
          chk({tag, "/res_full"}, {eq0, gt0, lt0}, res_exp);
          prev0 = res_exp;
        end else begin
          chk({tag, "/hold_full"}, {eq0, gt0, lt0}, prev0);
        end
      end
    end
    chk({tag, "/lat_ee"}, k1, k1_exp);
    chk({tag, "/lat_full"}, k0, k0_exp);
    @(posedge clk); #1;
    chk({tag, "/done_pulse"}, {done1, done0}, 2'b00);
    $display("job %s a=%02h b=%02h sm=%0d ceq=%0d cgt=%0d k_ee=%0d k_full=%0d eq/gt/lt=%03b",
             tag, ta, tb_v, sm, ce, cg, k1, k0, {eq1, gt1, lt1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd1, nd0, k;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ee", {busy1, done1, eq1, gt1, lt1}, 5'b0);
    chk("reset_full", {busy0, done0, eq0, gt0, lt0}, 5'b0);
    @(negedge clk) rst_n = 1'b1;

    run_job("eq_5a",      8'h5A, 8'h5A, 0, 1, 0, 4, 4, 3'b100);
    run_job("u_80_7f",    8'h80, 8'h7F, 0, 1, 0, 1, 4, 3'b010);
    run_job("s_80_7f",    8'h80, 8'h7F, 1, 1, 0, 1, 4, 3'b001);
    run_job("u_12_13",    8'h12, 8'h13, 0, 1, 0, 4, 4, 3'b001);
    run_job("u_34_38",    8'h34, 8'h38, 0, 1, 0, 3, 4, 3'b001);
    run_job("cas_gt",     8'h00, 8'hFF, 0, 0, 1, 1, 4, 3'b010);
    run_job("cas_lt",     8'hFF, 8'h00, 0, 0, 0, 1, 4, 3'b001);
    run_job("u_c0_40",    8'hC0, 8'h40, 0, 1, 0, 1, 4, 3'b010);
    run_job("s_ff_ff",    8'hFF, 8'hFF, 1, 1, 0, 4, 4, 3'b100);

    // Start held high: second job accepted only after DONE -> IDLE.
    @(negedge clk);
    a = 8'h12; b = 8'h13; signed_mode = 0; cas_eq_in = 1; cas_gt_in = 0; start = 1'b1;
    @(posedge clk); #1;
    nd1 = 0; nd0 = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      nd1 += int'(done1);
      nd0 += int'(done0);
      if (c == 5) chk("held/idle_gap", {busy1, busy0}, 2'b00);
      if (c == 6) chk("held/reaccept", {busy1, busy0}, 2'b11);
    end
    start = 1'b0;
    chk("held/done_count_ee", nd1, 1);
    chk("held/done_count_full", nd0, 1);
    k = 0;
    for (int c = 1; c <= 8 && k == 0; c++) begin
      @(posedge clk); #1;
      if (done1) k = c;
    end
    chk("held/lat2", k, 4);
    chk("held/res2", {eq1, gt1, lt1, eq0, gt0, lt0}, 6'b001001);
    prev1 = 3'b001; prev0 = 3'b001;
    @(posedge clk); #1;
    $display("job held_start second job k=%0d eq/gt/lt=%03b", k, {eq1, gt1, lt1});

    // Reset in the second RUN cycle of the full-length instance.
    @(negedge clk);
    a = 8'h00; b = 8'hFF; signed_mode = 0; cas_eq_in = 1; cas_gt_in = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_ee", {busy1, done1, eq1, gt1, lt1}, 5'b0);
    chk("midreset_full", {busy0, done0, eq0, gt0, lt0}, 5'b0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("midreset_nodone", {done1, done0}, 2'b00);
    end
    @(negedge clk) rst_n = 1'b1;
    prev1 = 3'b000; prev0 = 3'b000;
    $display("job midreset applied");
    run_job("post_rst_33", 8'h33, 8'h33, 0, 1, 0, 4, 4, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
